// File: rtl/intr_sched_if.sv
// Request/acknowledge bundle between the CP0 exception path and the interrupt scheduler.
interface intr_sched_if;
    logic [2:0] in_irq;
    logic [2:0] in_clr;
    logic       in_IE;
    logic [3:0] in_INM;
    logic       in_safe;
    logic       in_eret;
    logic       out_BK;
    logic       out_NIE;
    logic       out_flush;
    logic [1:0] out_code;
    logic [2:0] out_pending;
    logic [2:0] out_active;
    logic       out_busy;

    modport master (
        output in_irq, in_clr, in_IE, in_INM, in_safe, in_eret,
        input  out_BK, out_NIE, out_flush, out_code, out_pending, out_active, out_busy
    );

    modport slave (
        input  in_irq, in_clr, in_IE, in_INM, in_safe, in_eret,
        output out_BK, out_NIE, out_flush, out_code, out_pending, out_active, out_busy
    );
endinterface

// File: rtl/intr_sched.sv
// Fixed-priority interrupt scheduler: edge-latched requests, safe-point entry,
// and a per-source nesting record retired by eret.
module intr_sched #(
    parameter int NSRC = 3
) (
    input  logic         in_clk,
    input  logic         in_RST,
    intr_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ENTER, SERVICE} state_t;

    state_t          state, state_nx;
    logic [NSRC-1:0] irq_q, pending, active;
    logic [NSRC-1:0] rise, floor_mask, elig, enter_hot, retire_hot;
    logic [1:0]      code, code_nx, win;
    logic            live;
    logic            unused_inm;

    assign unused_inm = bus.in_INM[3];
    assign rise       = bus.in_irq & ~irq_q;
    assign enter_hot  = {{(NSRC-1){1'b0}}, 1'b1} << code;

    // Only sources above the most recently entered level may qualify.
    always_comb begin
        floor_mask = '1;
        retire_hot = '0;
        if (active[2]) begin
            floor_mask = 3'b000;
            retire_hot = 3'b100;
        end else if (active[1]) begin
            floor_mask = 3'b100;
            retire_hot = 3'b010;
        end else if (active[0]) begin
            floor_mask = 3'b110;
            retire_hot = 3'b001;
        end
    end

    assign elig = pending & ~bus.in_INM[NSRC-1:0] & floor_mask;
    assign live = bus.in_IE & (|elig);

    always_comb begin
        win = 2'd0;
        if (elig[2])      win = 2'd2;
        else if (elig[1]) win = 2'd1;
    end

    always_comb begin
        state_nx = state;
        code_nx  = code;
        case (state)
            IDLE:    if (live) state_nx = WAIT;
            WAIT: begin
                if (bus.in_safe && live) begin
                    state_nx = ENTER;
                    code_nx  = win;
                end else if (!live) begin
                    state_nx = (|active) ? SERVICE : IDLE;
                end
            end
            ENTER:   state_nx = SERVICE;
            SERVICE: begin
                if (bus.in_eret)
                    state_nx = (|(active & ~retire_hot)) ? SERVICE : IDLE;
                else if (live)
                    state_nx = WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_RST) begin
        if (in_RST) begin
            state   <= IDLE;
            code    <= '0;
            irq_q   <= '0;
            pending <= '0;
            active  <= '0;
        end else begin
            state <= state_nx;
            code  <= code_nx;
            irq_q <= bus.in_irq;
            // A fresh edge outranks both software clear and entry acknowledge.
            pending <= (pending & ~bus.in_clr & ~((state == ENTER) ? enter_hot : '0)) | rise;
            if (state == ENTER)
                active <= active | enter_hot;
            else if (state == SERVICE && bus.in_eret)
                active <= active & ~retire_hot;
        end
    end

    assign bus.out_BK      = (state == ENTER);
    assign bus.out_NIE     = (state == ENTER);
    assign bus.out_flush   = (state == ENTER);
    assign bus.out_code    = code;
    assign bus.out_pending = pending;
    assign bus.out_active  = active;
    assign bus.out_busy    = (state != IDLE);
endmodule

// File: tb/tb_intr_sched.sv
// Bench for intr_sched: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based nesting model.
module tb_intr_sched;
    logic in_clk = 1'b0;
    logic in_RST;

    intr_sched_if bus();
    intr_sched #(.NSRC(3)) dut (.in_clk(in_clk), .in_RST(in_RST), .bus(bus));

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] irq;
        logic [2:0] clr;
        logic       eret;
        logic       bk;
        logic [1:0] code;
        logic [2:0] pend;
        logic [2:0] act;
        logic       busy;
    } vec_t;

    vec_t tbl[25];

    // Reference model state: nesting kept as a stack of source indices.
    logic [2:0] m_pend, m_prev;
    int         m_stack[$];
    int         m_mode;   // 0 idle, 1 waiting, 2 entering, 3 servicing
    int         m_code;

    function automatic vec_t mk(input logic [2:0] irq, input logic [2:0] clr, input logic eret,
                                input logic bk, input logic [1:0] code, input logic [2:0] pend,
                                input logic [2:0] act, input logic busy);
        vec_t v;
        v.irq = irq; v.clr = clr; v.eret = eret; v.bk = bk;
        v.code = code; v.pend = pend; v.act = act; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] irq, input logic [2:0] clr, input logic ie,
                          input logic [3:0] inm, input logic safe, input logic eret);
        bus.in_irq = irq; bus.in_clr = clr; bus.in_IE = ie;
        bus.in_INM = inm; bus.in_safe = safe; bus.in_eret = eret;
    endtask

    task automatic do_reset();
        set_in(3'b000, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b0);
        in_RST = 1'b1;
        cyc();
        cyc();
        in_RST = 1'b0;
        m_pend = '0; m_prev = '0; m_stack.delete(); m_mode = 0; m_code = 0;
    endtask

    task automatic chk_outs(input string tag, input logic bk, input int code, input int pend,
                            input int act, input logic busy);
        chk({tag, "_bk"}, bus.out_BK, bk);
        chk({tag, "_nie"}, bus.out_NIE, bk);
        chk({tag, "_flush"}, bus.out_flush, bk);
        chk({tag, "_code"}, bus.out_code, code);
        chk({tag, "_pend"}, bus.out_pending, pend);
        chk({tag, "_act"}, bus.out_active, act);
        chk({tag, "_busy"}, bus.out_busy, busy);
    endtask

    task automatic model_step(input logic [2:0] irq, input logic [2:0] clr, input logic ie,
                              input logic [3:0] inm, input logic safe, input logic eret);
        logic [2:0] rise, elig, ent;
        int win, dummy;
        logic live;
        rise = irq & ~m_prev;
        elig = '0;
        ent  = '0;
        win  = 0;
        for (int i = 0; i < 3; i++)
            if (m_pend[i] && !inm[i] && (m_stack.size() == 0 || i > m_stack[$])) begin
                elig[i] = 1'b1;
                win = i;
            end
        live = ie && (elig != 0);
        case (m_mode)
            0: if (live) m_mode = 1;
            1: if (safe && live) begin m_mode = 2; m_code = win; end
               else if (!live) m_mode = (m_stack.size() != 0) ? 3 : 0;
            2: begin m_stack.push_back(m_code); ent[m_code] = 1'b1; m_mode = 3; end
            default: if (eret) begin
                         dummy = m_stack.pop_back();
                         m_mode = (m_stack.size() != 0) ? 3 : 0;
                     end else if (live) m_mode = 1;
        endcase
        m_pend = (m_pend & ~clr & ~ent) | rise;
        m_prev = irq;
    endtask

    function automatic int model_active();
        int a = 0;
        foreach (m_stack[k]) a |= (1 << m_stack[k]);
        return a;
    endfunction

    initial begin
        logic [2:0] r_irq, r_clr;
        logic [3:0] r_inm;
        logic       r_ie, r_safe, r_eret;

        tbl[0]  = mk(3'b001, 3'b000, 0, 0, 0, 3'b001, 3'b000, 0);
        tbl[1]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b000, 1);
        tbl[2]  = mk(3'b000, 3'b000, 0, 1, 0, 3'b001, 3'b000, 1);
        tbl[3]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b001, 1);
        tbl[4]  = mk(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0);
        tbl[5]  = mk(3'b101, 3'b000, 0, 0, 0, 3'b101, 3'b000, 0);
        tbl[6]  = mk(3'b000, 3'b000, 0, 0, 0, 3'b101, 3'b000, 1);
        tbl[7]  = mk(3'b000, 3'b000, 0, 1, 2, 3'b101, 3'b000, 1);
        tbl[8]  = mk(3'b000, 3'b000, 0, 0, 2, 3'b001, 3'b100, 1);
        tbl[9]  = mk(3'b000, 3'b000, 1, 0, 2, 3'b001, 3'b000, 0);
        tbl[10] = mk(3'b000, 3'b000, 0, 0, 2, 3'b001, 3'b000, 1);
        tbl[11] = mk(3'b000, 3'b000, 0, 1, 0, 3'b001, 3'b000, 1);
        tbl[12] = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b001, 1);
        tbl[13] = mk(3'b010, 3'b000, 0, 0, 0, 3'b010, 3'b001, 1);
        tbl[14] = mk(3'b000, 3'b000, 0, 0, 0, 3'b010, 3'b001, 1);
        tbl[15] = mk(3'b000, 3'b000, 0, 1, 1, 3'b010, 3'b001, 1);
        tbl[16] = mk(3'b000, 3'b000, 0, 0, 1, 3'b000, 3'b011, 1);
        tbl[17] = mk(3'b001, 3'b000, 0, 0, 1, 3'b001, 3'b011, 1);
        tbl[18] = mk(3'b000, 3'b000, 1, 0, 1, 3'b001, 3'b001, 1);
        tbl[19] = mk(3'b000, 3'b000, 0, 0, 1, 3'b001, 3'b001, 1);
        tbl[20] = mk(3'b000, 3'b000, 1, 0, 1, 3'b001, 3'b000, 0);
        tbl[21] = mk(3'b000, 3'b000, 0, 0, 1, 3'b001, 3'b000, 1);
        tbl[22] = mk(3'b000, 3'b000, 0, 1, 0, 3'b001, 3'b000, 1);
        tbl[23] = mk(3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b001, 1);
        tbl[24] = mk(3'b000, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0);

        do_reset();
        chk_outs("reset", 0, 0, 0, 0, 0);

        // Single entry, priority, nesting
        foreach (tbl[n]) begin
            set_in(tbl[n].irq, tbl[n].clr, 1'b1, 4'b0000, 1'b1, tbl[n].eret);
            cyc();
            chk_outs($sformatf("vec%0d", n), tbl[n].bk, tbl[n].code, tbl[n].pend, tbl[n].act, tbl[n].busy);
        end

        // Masked source stays pending; unmasking enters; in_safe low stretches WAIT
        set_in(3'b100, 3'b000, 1'b1, 4'b0100, 1'b1, 1'b0); cyc();
        set_in(3'b000, 3'b000, 1'b1, 4'b0100, 1'b1, 1'b0);
        repeat (3) cyc();
        chk_outs("mask_hold", 0, 0, 3'b100, 0, 0);
        set_in(3'b000, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b0); cyc();
        chk("unmask_wait_busy", bus.out_busy, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("safe_gate_bk%0d", k), bus.out_BK, 0);
        end
        bus.in_safe = 1'b1; cyc();
        chk_outs("safe_enter", 1, 2, 3'b100, 0, 1);
        cyc();
        chk_outs("safe_service", 0, 2, 0, 3'b100, 1);
        bus.in_eret = 1'b1; cyc(); bus.in_eret = 1'b0;
        chk_outs("safe_retire", 0, 2, 0, 0, 0);

        // IE dropped while waiting
        set_in(3'b001, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b0); cyc();
        bus.in_irq = 3'b000; cyc();
        chk("ie_drop_wait", bus.out_busy, 1);
        bus.in_IE = 1'b0; cyc();
        chk_outs("ie_drop_idle", 0, 2, 3'b001, 0, 0);
        bus.in_clr = 3'b001; cyc(); bus.in_clr = 3'b000;
        chk("sw_clear", bus.out_pending, 0);

        // Clear coincident with a new edge
        set_in(3'b010, 3'b010, 1'b0, 4'b0000, 1'b1, 1'b0); cyc();
        chk("clr_vs_set", bus.out_pending, 3'b010);
        set_in(3'b000, 3'b010, 1'b0, 4'b0000, 1'b1, 1'b0); cyc();
        chk("clr_only", bus.out_pending, 0);

        // eret and a live higher request in the same cycle
        set_in(3'b001, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b0); cyc();
        bus.in_irq = 3'b000; cyc(); cyc(); cyc();
        chk("svc0_act", bus.out_active, 3'b001);
        bus.in_irq = 3'b010; cyc();
        chk("svc0_pend1", bus.out_pending, 3'b010);
        set_in(3'b000, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b1); cyc(); bus.in_eret = 1'b0;
        chk_outs("eret_first", 0, 0, 3'b010, 0, 0);
        cyc();
        chk_outs("then_wait", 0, 0, 3'b010, 0, 1);
        cyc();
        chk_outs("then_enter", 1, 1, 3'b010, 0, 1);
        cyc(); bus.in_eret = 1'b1; cyc(); bus.in_eret = 1'b0;
        chk("eret_idle", bus.out_busy, 0);

        // Asynchronous reset in the middle of ENTER
        set_in(3'b101, 3'b000, 1'b1, 4'b0000, 1'b1, 1'b0); cyc();
        bus.in_irq = 3'b000; cyc(); cyc();
        chk("pre_rst_bk", bus.out_BK, 1);
        #2 in_RST = 1'b1;
        #1 chk_outs("async_rst", 0, 0, 0, 0, 0);
        #2 in_RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("post_rst_bk%0d", k), bus.out_BK, 0);
        end

        // Randomized traffic against the model
        do_reset();
        r_irq = '0; r_inm = '0;
        for (int n = 0; n < 3000; n++) begin
            r_irq  = r_irq ^ (3'($urandom) & 3'($urandom));
            r_clr  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            r_ie   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) r_inm = 4'($urandom) & 4'($urandom);
            r_safe = ($urandom_range(0, 3) != 0);
            r_eret = ($urandom_range(0, 3) == 0);
            set_in(r_irq, r_clr, r_ie, r_inm, r_safe, r_eret);
            model_step(r_irq, r_clr, r_ie, r_inm, r_safe, r_eret);
            cyc();
            chk_outs("rnd", m_mode == 2, m_code, m_pend, model_active(), m_mode != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intr_sched.md
# intr_sched

Interrupt scheduler for the CPU's exception path. It latches button-style interrupt requests from three sources and arbitrates them by fixed priority against the CP0 enable (IE) and mask (INM) state. It waits for a safe pipeline point, then issues a one-cycle break pulse with the source code and IE-clear to the register file / CP0 block. It tracks nested service levels until each matching `eret` retires.

## Interface

Parameters:
- `NSRC`, 3, number of interrupt sources; fixed at 3 in this revision because the code output is 2 bits.

Ports:
- `in_clk` input 1: the single clock; all state updates on the rising edge.
- `in_RST` input 1: asynchronous, active-high reset.
- `in_irq` input 3: request lines, synchronous to `in_clk`. A rising edge on bit i requests source i. Source 2 has the highest priority.
- `in_clr` input 3: software clear of pending bits. Bit i clears pending[i].
- `in_IE` input 1: global interrupt enable from CP0.
- `in_INM` input 4: mask bits from CP0. Bit i = 1 masks source i. Bit 3 is ignored.
- `in_safe` input 1: the pipeline can take a break this cycle (valid instruction in WB, no stall).
- `in_eret` input 1: an `eret` retires in WB this cycle.
- `out_BK` output 1: break pulse, one cycle.
- `out_NIE` output 1: clear-IE pulse, coincident with `out_BK`.
- `out_flush` output 1: pipeline flush pulse, coincident with `out_BK`.
- `out_code` output 2: source index of the break being entered. Held at its last value otherwise.
- `out_pending` output 3: pending request bits.
- `out_active` output 3: sources currently in service, one bit per nesting level.
- `out_busy` output 1: high when state is not IDLE.

## Operation

Edge detection:
- A registered copy of `in_irq` is kept.
- pending[i] is set when in_irq[i] = 1 and the previous sample was 0.
- pending[i] is cleared by in_clr[i] or by entering source i.
- Same-cycle conflicts: a set wins over both the clear and the entry acknowledge, so pending stays 1.

Eligibility:
- elig[i] = pending[i] & ~in_INM[i] & (i > index of the highest set bit of active).
- When active = 0, every unmasked pending source qualifies.
- winner = highest-index elig bit.
- A request is live when in_IE = 1 and elig ≠ 0.

State machine (IDLE, WAIT, ENTER, SERVICE):
- IDLE:
  - live → WAIT.
- WAIT:
  - in_safe & live → ENTER; the winner is latched into `out_code` on this transition.
  - Not live → return to SERVICE if active ≠ 0, otherwise IDLE.
  - Otherwise stay in WAIT, re-evaluating the winner every cycle.
- ENTER, one cycle:
  - `out_BK` = `out_NIE` = `out_flush` = 1.
  - active[code] is set and pending[code] is cleared on exit.
  - Next state is SERVICE.
- SERVICE:
  - in_eret → clear the highest set bit of active. If active becomes 0 → IDLE, else stay in SERVICE.
  - Else live → WAIT (nesting; only a higher-priority source can qualify).
  - eret has precedence over preemption in the same cycle. Preemption is re-evaluated on the next cycle.
- in_eret outside SERVICE is ignored.

Reset (asynchronous, at any time, including mid-ENTER):
- Everything clears immediately: state = IDLE; pending, active, and the previous irq sample = 0; `out_code` = 0.
- All pulses drop immediately.

## Timing

- Reset values: `out_BK`, `out_NIE`, `out_flush`, `out_busy` = 0; `out_code` = 0; `out_pending` and `out_active` = 0.
- Latency: a rising edge sampled at edge t gives pending at t+1, WAIT at t+2, and ENTER with pulses at t+3, provided in_safe = 1 during the WAIT cycle. Each cycle with in_safe = 0 adds one cycle.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Pulses are exactly one cycle and never occur on back-to-back cycles. Minimum spacing is 3 cycles (ENTER → SERVICE → WAIT → ENTER).
- Nesting depth is at most 3, one per source. A source already active can never re-enter until its level is retired.

## Test plan

1. Single request, safe pipeline:
   - Stimulus: reset, IE = 1, INM = 0, pulse in_irq[0] at cycle 5, in_safe = 1.
   - Required: pending = 001 at 6; BK/NIE/flush for exactly one cycle at 8 with code = 0; active = 001.
   - Then eret → active = 000, busy = 0.
2. Priority:
   - Stimulus: irq[0] and irq[2] rise in the same cycle.
   - Required: first entry has code = 2, with pending = 001 left.
   - After eret, the scheduler re-enters with code = 0.
3. Nesting:
   - Stimulus: in service of source 0, raise irq[1] with IE = 1.
   - Required: preempted entry with code = 1; active = 011.
   - First eret → active = 001, state SERVICE. Second eret → IDLE.
   - Raising irq[0] while active = 001 does not enter.
4. Masking and in_safe gating:
   - Stimulus: INM = 0100 with irq[2] pending.
   - Required: no entry; pending stays 100. Clearing INM[2] enters source 2.
   - With in_safe held at 0 for 4 cycles, BK is delayed exactly 4 cycles.
   - Dropping IE while in WAIT → return to IDLE with no pulse.
5. Same-cycle conflicts:
   - in_clr[1] with a new irq[1] edge → pending[1] stays 1.
   - eret with a live higher-priority request in the same cycle → retire first, WAIT on the next cycle.
6. Asynchronous reset:
   - Stimulus: assert in_RST mid-cycle during ENTER.
   - Required: BK falls immediately; state, pending, and active are all 0; no pulse after release.
